// File: rtl/lms_adapt_ctrl_if.sv
// Control/status bundle between the receiver control logic and the LMS
// adaptation sequencer. The master drives the requests and the symbol
// strobe; the slave (the sequencer) drives the LMS controls and status.
interface lms_adapt_ctrl_if;
  logic              i_start;
  logic              i_stop;
  logic              i_freeze;
  logic              i_valid;
  logic signed [7:0] i_error;
  logic              o_lms_rst;
  logic              o_lms_en;
  logic signed [7:0] o_mu;
  logic [2:0]        o_state;
  logic [2:0]        o_gear;
  logic              o_locked;
  logic [7:0]        o_retrain_cnt;

  modport master (
    output i_start, i_stop, i_freeze, i_valid, i_error,
    input  o_lms_rst, o_lms_en, o_mu, o_state, o_gear, o_locked, o_retrain_cnt
  );

  modport slave (
    input  i_start, i_stop, i_freeze, i_valid, i_error,
    output o_lms_rst, o_lms_en, o_mu, o_state, o_gear, o_locked, o_retrain_cnt
  );
endinterface

// File: rtl/lms_adapt_ctrl.sv
// LMS adaptation sequencer: clears the taps, walks a gear-shift step-size
// schedule from acquisition to tracking, and watches a windowed |error|
// sum to report lock and to retrain when tracking diverges.
module lms_adapt_ctrl #(
  parameter int MU_ACQ     = 64,
  parameter int N_GEARS    = 4,
  parameter int GEAR_LEN   = 1024,
  parameter int CLR_CYCLES = 2,
  parameter int WIN_LOG2   = 6,
  parameter int LOCK_THR   = 512,
  parameter int DIV_THR    = 4096
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  lms_adapt_ctrl_if.slave bus
);

  localparam int ACC_W = WIN_LOG2 + 7;
  localparam int SYM_W = $clog2(GEAR_LEN + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic signed [7:0] MU_INIT = 8'(MU_ACQ);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACQ   = 3'd2,
    TRACK = 3'd3
  } state_t;

  state_t             state, state_next;
  logic [CLR_W-1:0]   clr_cnt;
  logic [SYM_W-1:0]   sym_cnt;
  logic [2:0]         gear;
  logic signed [7:0]  mu;
  logic [ACC_W-1:0]   acc;
  logic [WIN_LOG2-1:0] win_cnt;
  logic               locked;
  logic [7:0]         retrain_cnt;
  logic               lms_rst;

  logic               sym_en;
  logic [7:0]         err_neg;
  logic [6:0]         err_abs;
  logic               win_last;
  logic [ACC_W-1:0]   sum;
  logic               diverge;
  logic               gear_adv;
  logic               gear_to_track;
  logic               clr_done;
  logic [2:0]         gear_inc;

  // An enabled symbol is one LMS actually adapts on; freeze suppresses it.
  assign sym_en   = ((state == ACQ) || (state == TRACK)) && bus.i_valid && !bus.i_freeze;

  // Magnitude with -128 saturated to 127 so it fits in 7 bits.
  assign err_neg  = -bus.i_error;
  assign err_abs  = !bus.i_error[7] ? bus.i_error[6:0] :
                    (bus.i_error == 8'sh80) ? 7'h7f : err_neg[6:0];

  assign win_last = sym_en && (win_cnt == '1);
  assign sum      = acc + ACC_W'(err_abs);
  assign diverge  = win_last && (state == TRACK) && (int'(sum) > DIV_THR);

  assign gear_inc      = gear + 3'd1;
  assign gear_adv      = sym_en && (state == ACQ) && (sym_cnt == SYM_W'(GEAR_LEN - 1));
  assign gear_to_track = (int'(gear_inc) >= N_GEARS - 1);
  assign clr_done      = (state == CLEAR) && (clr_cnt == CLR_W'(CLR_CYCLES - 1));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state: stop beats start beats divergence beats gear advance.
  always_comb begin
    state_next = state;
    if (bus.i_stop) begin
      state_next = IDLE;
    end else if (bus.i_start) begin
      state_next = CLEAR;
    end else begin
      case (state)
        CLEAR:   if (clr_done) state_next = (N_GEARS <= 1) ? TRACK : ACQ;
        ACQ:     if (gear_adv && gear_to_track) state_next = TRACK;
        TRACK:   if (diverge) state_next = CLEAR;
        default: state_next = state;
      endcase
    end
  end

  // Clear pulse, step-size schedule, error window, lock and retrain count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_cnt     <= '0;
      sym_cnt     <= '0;
      gear        <= '0;
      mu          <= '0;
      acc         <= '0;
      win_cnt     <= '0;
      locked      <= 1'b0;
      retrain_cnt <= '0;
      lms_rst     <= 1'b0;
    end else begin
      lms_rst <= (state_next == CLEAR);
      if (bus.i_stop) begin
        mu     <= '0;
        locked <= 1'b0;
      end else if (bus.i_start) begin
        clr_cnt <= '0;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + CLR_W'(1);
        if (clr_done) begin
          clr_cnt <= '0;
          gear    <= '0;
          mu      <= MU_INIT;
          sym_cnt <= '0;
          acc     <= '0;
          win_cnt <= '0;
          locked  <= 1'b0;
        end
      end else if (sym_en) begin
        win_cnt <= win_cnt + 1'b1;
        if (win_last) begin
          acc    <= '0;
          locked <= (state == TRACK) && (int'(sum) <= LOCK_THR);
        end else begin
          acc <= sum;
        end
        if (diverge) begin
          clr_cnt <= '0;
          locked  <= 1'b0;
          if (retrain_cnt != 8'hff) retrain_cnt <= retrain_cnt + 8'd1;
        end
        if (gear_adv) begin
          sym_cnt <= '0;
          gear    <= gear_inc;
          mu      <= MU_INIT >>> gear_inc;
        end else if (state == ACQ) begin
          sym_cnt <= sym_cnt + SYM_W'(1);
        end
      end
    end
  end

  assign bus.o_lms_rst     = lms_rst;
  assign bus.o_lms_en      = sym_en;
  assign bus.o_mu          = mu;
  assign bus.o_state       = state;
  assign bus.o_gear        = gear;
  assign bus.o_locked      = locked;
  assign bus.o_retrain_cnt = retrain_cnt;

endmodule

// File: doc/lms_adapt_ctrl.md
# lms_adapt_ctrl

Adaptation sequencer for the `lms` coefficient-update block of the equalizer. It clears the taps on request and drives the LMS update enable and step size. The step size follows a gear-shift schedule: large mu for acquisition, halved per gear down to a tracking value. A windowed |error| monitor reports lock and triggers automatic retraining on divergence. The block sits between the receiver control registers and `lms`, and its outputs connect directly to the LMS `i_rst`, `i_en` and `i_mu`.

## Interface
- `MU_ACQ`, 64: signed 8-bit acquisition step size, used at gear 0.
- `N_GEARS`, 4: number of gears. Gear g uses mu = `MU_ACQ >>> g`, for g = 0..`N_GEARS`-1. The last gear is tracking.
- `GEAR_LEN`, 1024: enabled symbols spent in each acquisition gear. Must be at least 1.
- `CLR_CYCLES`, 2: clock cycles for which the LMS clear is asserted.
- `WIN_LOG2`, 6: the error window is 2^`WIN_LOG2` enabled symbols.
- `LOCK_THR`, 512: lock is declared when the window sum is ≤ this value.
- `DIV_THR`, 4096: divergence is declared when the window sum is > this value, in tracking only.

- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_start`, in, 1: pulse that starts or restarts training.
- `i_stop`, in, 1: pulse that returns the block to idle.
- `i_freeze`, in, 1: level that holds adaptation.
- `i_valid`, in, 1: symbol strobe, aligned with LMS `i_data`/`i_error`.
- `i_error`, in, 8, signed: slicer error.
- `o_lms_rst`, out, 1: synchronous active-high clear to LMS. Registered.
- `o_lms_en`, out, 1: LMS update enable. Combinational.
- `o_mu`, out, 8, signed: step size. Registered.
- `o_state`, out, 3: encoded state.
- `o_gear`, out, 3: current gear index.
- `o_locked`, out, 1: lock indicator. Registered.
- `o_retrain_cnt`, out, 8: saturating count of divergence-triggered retrains.

## Operation
- State encoding: IDLE=0, CLEAR=1, ACQ=2, TRACK=3.
- **IDLE**
  - `o_mu`=0, `o_lms_en`=0.
  - `i_start` → CLEAR.
- **CLEAR**
  - `o_lms_rst`=1 for exactly `CLR_CYCLES` cycles, then → ACQ.
  - On entering ACQ: gear=0, `o_mu`=`MU_ACQ`, symbol counter=0, window cleared, `o_locked`=0.
- **ACQ**
  - `o_lms_en` = `i_valid` & ~`i_freeze`.
  - Each enabled symbol increments the symbol counter.
  - When the counter reaches `GEAR_LEN`-1 on an enabled symbol: counter←0 and gear←gear+1, with mu updated on the same edge.
  - If the new gear is `N_GEARS`-1 → TRACK.
- **TRACK**
  - `o_lms_en` as in ACQ; gear and mu are held.
- **Error monitor**, active in ACQ and TRACK on enabled symbols only.
  - abs = |`i_error`|, with -128 saturated to 127.
  - The accumulator is `WIN_LOG2`+7 bits and cannot overflow.
  - On the final symbol of a window, sum = acc + abs is evaluated and the accumulator is restarted from 0.
  - `o_locked` ← (state is TRACK) & (sum ≤ `LOCK_THR`).
  - In TRACK, if sum > `DIV_THR`: → CLEAR, `o_retrain_cnt` +1 (saturating at 255), `o_locked`←0.
- **Freeze**
  - `i_freeze`=1 forces `o_lms_en`=0.
  - Counters, window, gear and mu are all held.
  - Ignored in CLEAR: the clear always completes.
- **Priority**, highest first:
  1. `i_stop`: → IDLE from any state; `o_mu`←0, `o_locked`←0.
  2. `i_start`: → CLEAR from any state, including a restart from ACQ or TRACK.
  3. Divergence.
  4. Gear advance.
- Simultaneous divergence and gear advance cannot occur, because divergence is evaluated in TRACK only.
- `o_retrain_cnt` is cleared only by reset. `i_start` does not count as a retrain.

## Timing
- Reset values:
  - state IDLE.
  - `o_lms_rst`=0, `o_lms_en`=0, `o_mu`=0, `o_gear`=0, `o_locked`=0, `o_retrain_cnt`=0.
  - All counters 0.
- `i_start` sampled at edge k: `o_lms_rst`=1 during cycles k+1..k+`CLR_CYCLES`. State is ACQ and `o_mu`=`MU_ACQ` from cycle k+`CLR_CYCLES`+1.
- `o_lms_en` is a zero-latency function of `i_valid`, `i_freeze` and the registered state. This keeps the enable aligned with the symbol that LMS samples.
- A gear change or lock update caused by the enabled symbol at edge k is visible after edge k, so the next symbol uses the new mu.
- Divergence detected at edge k: `o_lms_en`=0 from cycle k+1, and the clear sequence starts exactly as for `i_start`.
- Reset mid-operation aborts immediately; all outputs take their reset values asynchronously.

## Test plan
Parameters for all scenarios: `MU_ACQ`=64, `N_GEARS`=3, `GEAR_LEN`=4, `CLR_CYCLES`=2, `WIN_LOG2`=2, `LOCK_THR`=8, `DIV_THR`=200.
1. **Basic training:** reset, then `i_start`, then `i_valid`=1 continuously with `i_error`=0.
   - `o_lms_rst` is high for 2 cycles.
   - `o_mu` goes 64 for 4 symbols, then 32 for 4 symbols, then 16 in TRACK (`o_state`=3, `o_gear`=2).
   - `o_locked`=1 after the first complete window in TRACK.
2. **Freeze:** toggle `i_freeze` for 5 cycles mid-gear-0.
   - `o_lms_en`=0 during the freeze.
   - The gear-1 transition is delayed by exactly 5 valid cycles.
3. **Divergence:** in TRACK, drive `i_error`=-128 for 4 symbols.
   - sum = 508 > 200, so the block returns to CLEAR.
   - `o_retrain_cnt`=1 and `o_locked`=0; the mu schedule restarts at 64.
4. **Lock boundary:** in TRACK, drive a window with `i_error` = {2, -2, 2, 2} → sum 8, `o_locked`=1. Then drive {3, 2, 2, 2} → sum 9, `o_locked`=0.
5. **Stop/start collision:** assert `i_stop` and `i_start` in the same cycle during ACQ.
   - The block goes to IDLE with `o_mu`=0 and `o_lms_rst` not asserted.
   - A later `i_start` in TRACK restarts via CLEAR without incrementing `o_retrain_cnt`.
6. **Async reset:** assert `i_rst_n`=0 mid-CLEAR. All outputs go to their reset values before the next clock edge.
